// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stage indices and default sizing for the pipeline sequencer
package pipe_ctrl_pkg;
  localparam int ST_IF = 0;
  localparam int ST_ID = 1;
  localparam int ST_EX = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB = 4;
  localparam int DEF_NSTAGE = 5;
  localparam int DEF_MAX_OUTST = 3;
  localparam int DEF_CW = 4;
endpackage

// File: rtl/pipe_ctrl_reqtrack.sv
// pipe_ctrl_reqtrack: in-flight fetch counter and stale-response discard tracking
module pipe_ctrl_reqtrack
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = DEF_MAX_OUTST,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          inst_req_fire,
  input  logic          inst_resp,
  output logic          inst_req_ok,
  output logic          inst_resp_discard,
  output logic [CW-1:0] outstanding
);
  logic [CW-1:0] dcnt;
  logic [CW-1:0] out_n;
  assign out_n = outstanding + CW'(inst_req_fire) - CW'(inst_resp);
  assign inst_req_ok = (outstanding < CW'(MAX_OUTST)) | inst_resp;
  assign inst_resp_discard = inst_resp & (flush | (dcnt != '0));
  // a flush marks everything still in flight after this edge as stale
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      dcnt <= '0;
    end else begin
      outstanding <= out_n;
      dcnt <= flush ? out_n : dcnt - CW'(inst_resp && dcnt != '0);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inst_req_fire && !inst_resp && outstanding == CW'(MAX_OUTST)));
      assert (!(inst_resp && !inst_req_fire && outstanding == '0));
      assert (dcnt <= outstanding);
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage valid/allowin/load-enable sequencing with exception flush
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = DEF_NSTAGE,
  parameter int MAX_OUTST = DEF_MAX_OUTST,
  parameter int CW = DEF_CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_in_valid,
  input  logic [NSTAGE-1:0] ready_go,
  input  logic              wb_ex,
  input  logic              wb_ertn,
  input  logic              inst_req_fire,
  input  logic              inst_resp,
  output logic [NSTAGE-1:0] stage_valid,
  output logic [NSTAGE-1:0] allowin,
  output logic [NSTAGE-1:0] load_en,
  output logic [NSTAGE-1:0] to_next_valid,
  output logic              flush,
  output logic              inst_req_ok,
  output logic              inst_resp_discard,
  output logic [CW-1:0]     outstanding
);
  logic [NSTAGE-1:0] up;
  assign flush = stage_valid[NSTAGE-1] & (wb_ex | wb_ertn);
  assign to_next_valid = stage_valid & ready_go;
  assign up = {to_next_valid[NSTAGE-2:0], if_in_valid};
  assign load_en = allowin & up & {NSTAGE{!flush}};
  // stalls propagate backwards from WB within the same cycle
  always_comb begin
    allowin = '0;
    allowin[NSTAGE-1] = !stage_valid[NSTAGE-1] | ready_go[NSTAGE-1];
    for (int i = NSTAGE - 2; i >= 0; i--)
      allowin[i] = !stage_valid[i] | (ready_go[i] & allowin[i+1]);
  end
  always_ff @(posedge clk) begin
    if (rst || flush) stage_valid <= '0;
    else stage_valid <= (allowin & up) | (~allowin & stage_valid);
  end
  pipe_ctrl_reqtrack #(.MAX_OUTST(MAX_OUTST), .CW(CW)) u_reqtrack (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .inst_req_fire(inst_req_fire),
    .inst_resp(inst_resp),
    .inst_req_ok(inst_req_ok),
    .inst_resp_discard(inst_resp_discard),
    .outstanding(outstanding)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven directed checks plus a per-PC retirement scoreboard
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;
  logic clk = 0;
  logic rst = 1;
  logic if_in_valid = 0;
  logic [4:0] ready_go = 5'b11111;
  logic wb_ex = 0, wb_ertn = 0, inst_req_fire = 0, inst_resp = 0;
  logic [4:0] stage_valid, allowin, load_en, to_next_valid;
  logic flush, inst_req_ok, inst_resp_discard;
  logic [3:0] outstanding;
  pipe_ctrl dut (
    .clk(clk), .rst(rst), .if_in_valid(if_in_valid), .ready_go(ready_go),
    .wb_ex(wb_ex), .wb_ertn(wb_ertn), .inst_req_fire(inst_req_fire), .inst_resp(inst_resp),
    .stage_valid(stage_valid), .allowin(allowin), .load_en(load_en),
    .to_next_valid(to_next_valid), .flush(flush), .inst_req_ok(inst_req_ok),
    .inst_resp_discard(inst_resp_discard), .outstanding(outstanding)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, iv;
    logic [4:0] rg;
    logic ex, er, fi, rs;
    logic [4:0] ev, ea, el;
    logic ef, ed;
    logic [3:0] eo;
    logic ek;
  } vec_t;
  vec_t vq[$];
  int n_chk = 0, n_pass = 0;
  int pc[5];
  int next_pc = 0, exp_ret = 0;
  localparam logic [4:0] F = 5'b11111;
  function automatic vec_t mk(logic r, iv, logic [4:0] rg, logic ex, er, fi, rs,
                              logic [4:0] ev, ea, el, logic ef, ed, logic [3:0] eo, logic ek);
    mk = '{r, iv, rg, ex, er, fi, rs, ev, ea, el, ef, ed, eo, ek};
  endfunction
  task automatic chk(string nm, int idx, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL v%0d %s: got %0h expected %0h", idx, nm, act, exp);
  endtask
  task automatic step(vec_t v, int idx);
    @(negedge clk);
    rst = v.r; if_in_valid = v.iv; ready_go = v.rg; wb_ex = v.ex; wb_ertn = v.er;
    inst_req_fire = v.fi; inst_resp = v.rs;
    #1;
    chk("stage_valid", idx, stage_valid, v.ev);
    chk("allowin", idx, allowin, v.ea);
    chk("load_en", idx, load_en, v.el);
    chk("flush", idx, flush, v.ef);
    chk("discard", idx, inst_resp_discard, v.ed);
    chk("outstanding", idx, outstanding, v.eo);
    chk("inst_req_ok", idx, inst_req_ok, v.ek);
    if (v.r || flush) exp_ret = next_pc;
    else if (to_next_valid[ST_WB]) begin
      chk("retire_pc", idx, pc[ST_WB], exp_ret);
      exp_ret++;
    end
    for (int i = 4; i > 0; i--) if (load_en[i]) pc[i] = pc[i-1];
    if (load_en[ST_IF]) pc[ST_IF] = next_pc++;
  endtask
  initial begin
    // reset state
    vq.push_back(mk(1,0,F,0,0,0,0, 5'b00000,F,5'b00000,0,0,0,1));
    // free flow fill
    vq.push_back(mk(0,1,F,0,0,0,0, 5'b00000,F,5'b00001,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,0, 5'b00001,F,5'b00011,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,0, 5'b00011,F,5'b00111,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,0, 5'b00111,F,5'b01111,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,0, 5'b01111,F,F,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,0, F,F,F,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,0, F,F,F,0,0,0,1));
    // MEM stall for two cycles
    vq.push_back(mk(0,1,5'b10111,0,0,0,0, F,5'b10000,5'b00000,0,0,0,1));
    vq.push_back(mk(0,1,5'b10111,0,0,0,0, 5'b01111,5'b10000,5'b00000,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,0, 5'b01111,F,F,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,0, F,F,F,0,0,0,1));
    // exception flush and refill
    vq.push_back(mk(0,1,F,1,0,0,0, F,F,5'b00000,1,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,0, 5'b00000,F,5'b00001,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,0, 5'b00001,F,5'b00011,0,0,0,1));
    // two fetches, then ertn with a simultaneous fetch: three stale responses
    vq.push_back(mk(0,1,F,0,0,1,0, 5'b00011,F,5'b00111,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,1,0, 5'b00111,F,5'b01111,0,0,1,1));
    vq.push_back(mk(0,1,F,0,0,0,0, 5'b01111,F,F,0,0,2,1));
    vq.push_back(mk(0,1,F,0,1,1,0, F,F,5'b00000,1,0,2,1));
    vq.push_back(mk(0,1,F,0,0,0,1, 5'b00000,F,5'b00001,0,1,3,1));
    vq.push_back(mk(0,1,F,0,0,0,1, 5'b00001,F,5'b00011,0,1,2,1));
    vq.push_back(mk(0,1,F,0,0,0,1, 5'b00011,F,5'b00111,0,1,1,1));
    vq.push_back(mk(0,1,F,0,0,1,0, 5'b00111,F,5'b01111,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,1, 5'b01111,F,F,0,0,1,1));
    vq.push_back(mk(0,1,F,0,0,0,0, F,F,F,0,0,0,1));
    // flush coinciding with a response
    vq.push_back(mk(0,1,F,0,0,1,0, F,F,F,0,0,0,1));
    vq.push_back(mk(0,1,F,1,0,0,1, F,F,5'b00000,1,1,1,1));
    vq.push_back(mk(0,1,F,0,0,0,0, 5'b00000,F,5'b00001,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,1,0, 5'b00001,F,5'b00011,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,0,1, 5'b00011,F,5'b00111,0,0,1,1));
    // outstanding limit
    vq.push_back(mk(0,1,F,0,0,1,0, 5'b00111,F,5'b01111,0,0,0,1));
    vq.push_back(mk(0,1,F,0,0,1,0, 5'b01111,F,F,0,0,1,1));
    vq.push_back(mk(0,1,F,0,0,1,0, F,F,F,0,0,2,1));
    vq.push_back(mk(0,1,F,0,0,0,0, F,F,F,0,0,3,0));
    vq.push_back(mk(0,1,F,0,0,1,1, F,F,F,0,0,3,1));
    vq.push_back(mk(0,1,F,0,0,0,0, F,F,F,0,0,3,0));
    rst = 1;
    repeat (2) @(negedge clk);
    foreach (vq[i]) step(vq[i], i);
    // reset asserted in the middle of a flush with requests in flight
    step(mk(1,1,F,1,0,0,0, F,F,5'b00000,1,0,3,0), 100);
    step(mk(0,0,F,0,0,0,0, 5'b00000,F,5'b00000,0,0,0,1), 101);
    step(mk(0,0,F,0,0,1,0, 5'b00000,F,5'b00000,0,0,0,1), 102);
    step(mk(0,0,F,0,0,0,1, 5'b00000,F,5'b00000,0,0,1,1), 103);
    step(mk(0,0,F,0,0,0,0, 5'b00000,F,5'b00000,0,0,0,1), 104);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
